// File: rtl/wts_mixer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wts_mixer_pkg
// Description : Shared constants for the envelope channel mixer: slot
//               encodings, envelope ceiling, datapath widths and the output
//               saturation limits.
// Revision    : 1.0 - initial release
// ============================================================================
package wts_mixer_pkg;

    typedef logic [2:0] slot_t;

    // Slot indices carried on the time-multiplexed envelope stream
    localparam slot_t SLOT_A    = 3'd0;
    localparam slot_t SLOT_B    = 3'd1;
    localparam slot_t SLOT_C    = 3'd2;
    localparam slot_t SLOT_D    = 3'd3;
    localparam slot_t SLOT_E    = 3'd4;
    localparam slot_t SLOT_EOF  = 3'd5;
    localparam slot_t SLOT_IDLE = 3'd7;

    localparam logic [4:0] ENV_MAX = 5'd16;

    localparam int WAVE_W = 8;   // signed wave sample
    localparam int ENV_W  = 5;   // envelope 0..16 (wider codes clamp)
    localparam int VOL_W  = 4;   // channel volume 0..15
    localparam int P1_W   = 12;  // wave * envelope, -2048..2032
    localparam int P2_W   = 17;  // p1 * volume before the shift

    localparam int SAT_MAX = 2047;
    localparam int SAT_MIN = -2048;

    // Envelope codes above the ceiling behave as full scale.
    function automatic logic [4:0] clamp_env(input logic [4:0] env);
        return (env > ENV_MAX) ? ENV_MAX : env;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wts_mixer_channel_scaler.sv
`default_nettype none
// ============================================================================
// Module      : wts_mixer_channel_scaler
// Description : Two-stage scaling pipeline for one slot per clock.
//               Stage 1: clamp envelope, apply channel enable mask,
//                        multiply wave by envelope (12-bit signed).
//               Stage 2: multiply by the channel volume and arithmetic
//                        right shift by VOL_SHIFT (floor rounding).
//               The slot tag travels alongside the data.
// Ports       : clk, nreset     - clock, async active-low reset
//               i_active        - slot index of the incoming sample
//               i_envelope      - envelope of that slot (0..31, clamps at 16)
//               i_wave          - signed wave sample
//               i_enable        - per-channel enable, bit0 = channel A
//               i_vol           - volume of the channel in stage 1 (o_tag1)
//               o_tag1, o_tag2  - slot tags of stage 1 and stage 2
//               o_p2            - scaled sample of stage 2, OUT_W signed
// Revision    : 1.0 - initial release
// ============================================================================
module wts_mixer_channel_scaler
    import wts_mixer_pkg::*;
#(
    parameter int OUT_W     = 15,
    parameter int VOL_SHIFT = 4
) (
    input  logic                    clk,
    input  logic                    nreset,
    input  logic [2:0]              i_active,
    input  logic [4:0]              i_envelope,
    input  logic [7:0]              i_wave,
    input  logic [4:0]              i_enable,
    input  logic [3:0]              i_vol,
    output logic [2:0]              o_tag1,
    output logic [2:0]              o_tag2,
    output logic signed [OUT_W-1:0] o_p2
);

    // ------------------------------------------------------------------
    // Stage 1
    // ------------------------------------------------------------------
    logic [4:0]             w_env;
    logic signed [P1_W-1:0] w_wave_ext;
    logic signed [P1_W-1:0] w_env_ext;
    logic signed [P1_W-1:0] w_p1;
    logic                   w_ch_en;

    logic signed [P1_W-1:0] r_p1;
    logic [2:0]             r_tag1;

    assign w_env      = clamp_env(i_envelope);
    assign w_wave_ext = {{(P1_W-WAVE_W){i_wave[WAVE_W-1]}}, i_wave};
    assign w_env_ext  = {{(P1_W-ENV_W){1'b0}}, w_env};

    // Only the channel slots are masked; EOF and idle slots carry no data
    // that ever reaches the accumulator.
    always_comb begin
        w_ch_en = 1'b1;
        case (i_active)
            SLOT_A:  w_ch_en = i_enable[0];
            SLOT_B:  w_ch_en = i_enable[1];
            SLOT_C:  w_ch_en = i_enable[2];
            SLOT_D:  w_ch_en = i_enable[3];
            SLOT_E:  w_ch_en = i_enable[4];
            default: w_ch_en = 1'b1;
        endcase
    end

    // |wave * env| <= 128 * 16 = 2048, so the low 12 bits are exact.
    assign w_p1 = w_ch_en ? (w_wave_ext * w_env_ext) : '0;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_p1   <= '0;
            r_tag1 <= SLOT_IDLE;
        end else begin
            r_p1   <= w_p1;
            r_tag1 <= i_active;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2
    // ------------------------------------------------------------------
    logic signed [P2_W-1:0]  w_p1_ext;
    logic signed [P2_W-1:0]  w_vol_ext;
    logic signed [P2_W-1:0]  w_prod2;

    logic signed [OUT_W-1:0] r_p2;
    logic [2:0]              r_tag2;

    assign w_p1_ext  = {{(P2_W-P1_W){r_p1[P1_W-1]}}, r_p1};
    assign w_vol_ext = {{(P2_W-VOL_W){1'b0}}, i_vol};
    assign w_prod2   = w_p1_ext * w_vol_ext;

    // Signed >>> floors toward minus infinity; the size cast sign-extends
    // or drops redundant sign bits to match the accumulator width.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_p2   <= '0;
            r_tag2 <= SLOT_IDLE;
        end else begin
            r_p2   <= OUT_W'(w_prod2 >>> VOL_SHIFT);
            r_tag2 <= r_tag1;
        end
    end

    assign o_tag1 = r_tag1;
    assign o_tag2 = r_tag2;
    assign o_p2   = r_p2;

endmodule
`default_nettype wire

// File: rtl/wts_envelope_channel_mixer.sv
`default_nettype none
// ============================================================================
// Module      : wts_envelope_channel_mixer
// Description : Mixes the time-multiplexed five-channel envelope stream into
//               one frame sample. Each slot is scaled by envelope and channel
//               volume, channels A..E are summed, and the sum is emitted when
//               the end-of-frame slot (5) reaches the accumulate stage.
//               Optional build macro WTS_MIXER_SATURATE_EN clamps the emitted
//               sample to -2048..2047; otherwise the full sum is passed.
// Ports       : clk, nreset           - clock, async active-low reset
//               active                - slot index (0..4 ch A..E, 5 EOF)
//               envelope, wave        - envelope and signed sample of the slot
//               reg_volume_a..e       - per-channel volume 0..15
//               reg_enable            - per-channel enable, bit0 = A
//               sound_out             - signed mixed frame sample
//               sound_valid           - one-cycle pulse on sound_out update
// Revision    : 1.0 - initial release
// ============================================================================
module wts_envelope_channel_mixer
    import wts_mixer_pkg::*;
#(
    parameter int ACC_W     = 15,
    parameter int VOL_SHIFT = 4
) (
    input  logic                    clk,
    input  logic                    nreset,
    input  logic [2:0]              active,
    input  logic [4:0]              envelope,
    input  logic [7:0]              wave,
    input  logic [3:0]              reg_volume_a,
    input  logic [3:0]              reg_volume_b,
    input  logic [3:0]              reg_volume_c,
    input  logic [3:0]              reg_volume_d,
    input  logic [3:0]              reg_volume_e,
    input  logic [4:0]              reg_enable,
    output logic signed [ACC_W-1:0] sound_out,
    output logic                    sound_valid
);

    logic [2:0]              w_tag1;
    logic [2:0]              w_tag2;
    logic signed [ACC_W-1:0] w_p2;
    logic [3:0]              w_vol;
    logic signed [ACC_W-1:0] w_out_sel;

    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] r_sound_out;
    logic                    r_sound_valid;

    // Volume is looked up live for the slot sitting in stage 1, so a
    // register write affects every slot that has not yet passed stage 2.
    always_comb begin
        w_vol = '0;
        case (w_tag1)
            SLOT_A:  w_vol = reg_volume_a;
            SLOT_B:  w_vol = reg_volume_b;
            SLOT_C:  w_vol = reg_volume_c;
            SLOT_D:  w_vol = reg_volume_d;
            SLOT_E:  w_vol = reg_volume_e;
            default: w_vol = '0;
        endcase
    end

    wts_mixer_channel_scaler #(
        .OUT_W     (ACC_W),
        .VOL_SHIFT (VOL_SHIFT)
    ) u_scaler (
        .clk        (clk),
        .nreset     (nreset),
        .i_active   (active),
        .i_envelope (envelope),
        .i_wave     (wave),
        .i_enable   (reg_enable),
        .i_vol      (w_vol),
        .o_tag1     (w_tag1),
        .o_tag2     (w_tag2),
        .o_p2       (w_p2)
    );

`ifdef WTS_MIXER_SATURATE_EN
    localparam logic signed [ACC_W-1:0] c_sat_max = ACC_W'(SAT_MAX);
    localparam logic signed [ACC_W-1:0] c_sat_min = ACC_W'(SAT_MIN);

    // Only the emitted sample is clamped; the running sum stays exact.
    always_comb begin
        w_out_sel = r_acc;
        if (r_acc > c_sat_max) begin
            w_out_sel = c_sat_max;
        end else if (r_acc < c_sat_min) begin
            w_out_sel = c_sat_min;
        end
    end
`else
    assign w_out_sel = r_acc;
`endif

    // Slot A restarts the frame sum, B..E add, EOF dumps and clears.
    // Five channels of at most 2048 cannot overflow a 15-bit signed sum.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_acc         <= '0;
            r_sound_out   <= '0;
            r_sound_valid <= 1'b0;
        end else begin
            r_sound_valid <= 1'b0;
            case (w_tag2)
                SLOT_A: begin
                    r_acc <= w_p2;
                end
                SLOT_B, SLOT_C, SLOT_D, SLOT_E: begin
                    r_acc <= r_acc + w_p2;
                end
                SLOT_EOF: begin
                    r_sound_out   <= w_out_sel;
                    r_sound_valid <= 1'b1;
                    r_acc         <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    assign sound_out   = r_sound_out;
    assign sound_valid = r_sound_valid;

endmodule
`default_nettype wire

// File: doc/wts_envelope_channel_mixer.md
Name: wts_envelope_channel_mixer

Overview:
Consumer of the time-multiplexed envelope stream produced by the 5-channel ADSR envelope generator. Each slot supplies a channel index (`active`), that channel's envelope (0..16) and its current wave sample. The block applies envelope and per-channel volume to the sample, then accumulates channels A..E into one frame sum. It emits the mixed sample once per frame when the no-op slot (5) passes, feeding the output DAC/filter stage.

Parameters:
ACC_W, 15, accumulator and output width (signed); must be at least 15 to hold 5 x 2048.
VOL_SHIFT, 4, right arithmetic shift applied after volume multiply.

Ports:
clk  input  1  system clock
nreset  input  1  asynchronous reset, active low
active  input  3  slot index: 0..4 = channel A..E, 5 = end-of-frame/no-op, 6..7 = ignored
envelope  input  5  envelope of slot channel, 0..16; values 17..31 clamp to 16
wave  input  8  signed wave sample of slot channel
reg_volume_a..reg_volume_e  input  4 each  channel volume, 0..15
reg_enable  input  5  per-channel enable, bit0 = A; 0 mutes the contribution
sound_out  output  ACC_W  signed mixed frame sample
sound_valid  output  1  one-cycle pulse when sound_out updates

Behaviour:
- Reset is asynchronous, active low. While nreset=0: sound_out=0, sound_valid=0, accumulator=0, all pipeline data=0, pipeline tags=7 (idle). Reset mid-frame discards the partial sum, and no sound_valid is produced for that frame.
- Stage 1 (registered at the clk edge ending cycle N):
  - env_c = min(envelope, 16).
  - p1 = wave * env_c, 12-bit signed, range -2048..2032.
  - tag1 = active.
  - p1 is forced to 0 when active is 0..4 and reg_enable[active]=0.
- Stage 2 (edge ending N+1):
  - p2 = (p1 * vol) >>> VOL_SHIFT, arithmetic shift with floor rounding (e.g. -1 -> -1).
  - vol is the reg_volume of channel tag1, sampled at this stage.
  - tag2 = tag1.
- Accumulate stage (edge ending N+2), selected by tag2:
  - tag2=0: acc <= sign-extended p2. This starts a new frame; the old sum is discarded.
  - tag2=1..4: acc <= acc + p2.
  - tag2=5: sound_out <= acc (saturated if feature enabled); sound_valid <= 1; acc <= 0.
  - tag2=6,7: no change.
- sound_valid is 0 in every cycle not produced by tag2=5.
- Latency: the slot-5 input in cycle M gives sound_out/sound_valid visible in cycle M+3. The slot-4 contribution from cycle M-1 is included.
- Slots are not required to be consecutive or in order:
  - Repeated indices accumulate repeatedly.
  - A missing slot 0 means accumulation continues from the previous value (0 after reset or after a slot-5 dump).
  - Back-to-back slot 5 gives a second pulse with sound_out=0.
- Register changes (volume, enable) take effect for any slot reaching the relevant stage after the change. No shadowing.
- No wrap possible: |acc| <= 5 x 2048 = 10240 < 2^14.

Optional Feature:
WTS_MIXER_SATURATE_EN:
- Defined: the value written to sound_out at tag2=5 is clamped to -2048..2047, sign-extended to ACC_W. The accumulator itself is unclamped.
- Undefined: the full accumulator value is passed unchanged.

Decomposition:
- Package wts_mixer_pkg: slot constants (SLOT_A..SLOT_E=0..4, SLOT_EOF=5, SLOT_IDLE=7), ENV_MAX=16, sample/product widths, saturation limits SAT_MAX=2047 / SAT_MIN=-2048.
- Sub-module wts_mixer_channel_scaler: stages 1 and 2 (clamp, enable mask, envelope multiply, volume multiply/shift, tag pipeline).
- The top level holds the volume mux, accumulator and output registers.

Test Plan:
- Reset: hold nreset=0 for 10 clocks, then release with active=7 -> sound_out=0 and sound_valid=0 for 50 cycles.
- Slots 0..5 on consecutive cycles, all wave=64, envelope=16, volume=15, enable=5'h1F -> sound_valid pulses exactly once, 3 cycles after slot 5, with sound_out=4800 (clamped build: 2047).
- Channel A only enabled, wave=-128, envelope=31 (clamp), volume=15 -> sound_out=-1920. Then wave=-1, envelope=1, volume=1 -> -1 (floor rounding).
- Enable=5'h00 with nonzero inputs -> sound_out=0, and sound_valid is still pulsed per frame.
- Assert nreset=0 after slots 0..2 of a frame, release, then send slot 5 -> no pulse during reset, then sound_out=0 with sound_valid=1.
- Two frames back-to-back with different envelopes (16, then 8, single channel wave=100, volume=15) -> outputs 1500 then 750, no carry-over between frames.
